// File: rtl/mul_issue_sched.sv
// Issue scheduler and in-order writeback buffer for the fixed-latency pipelined multiplier.
// Optional combinational writeback bypass of the capture slot: define MUL_WB_BYPASS_EN.
module mul_issue_sched #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_func_i,
  input  logic [4:0]       req_rd_i,
  input  logic [63:0]      req_opr_a_i,
  input  logic [63:0]      req_opr_b_i,
  input  logic             kill_i,
  output logic             mul_instr_o,
  output logic [2:0]       mul_func_o,
  output logic [63:0]      mul_opr_a_o,
  output logic [63:0]      mul_opr_b_o,
  input  logic [63:0]      mul_res_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [63:0]      wb_data_o,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic             hazard_o,
  output logic [OCC_W-1:0] occ_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

  logic [LATENCY-1:0] sh_valid_q, sh_valid_d;
  logic [4:0]         sh_rd_q [LATENCY];
  logic [4:0]         sh_rd_d [LATENCY];

  logic [4:0]         fifo_rd_q   [FIFO_DEPTH];
  logic [63:0]        fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;

  logic               fire, cap_valid, push, pop, fifo_empty, fifo_full;
  logic [4:0]         cap_rd;
  int unsigned        occ_sum;
  logic               hit1, hit2;

  // Credits come from registered state only, so a same-cycle pop never frees a slot early.
  always_comb begin
    occ_sum = 32'(count_q);
    for (int unsigned i = 0; i < LATENCY; i++) begin
      occ_sum = occ_sum + 32'(sh_valid_q[i]);
    end
  end

  assign req_ready_o = (occ_sum < FIFO_DEPTH);
  assign occ_o       = OCC_W'(occ_sum);
  assign fire        = req_valid_i & req_ready_o & ~kill_i;

  assign mul_instr_o = fire;
  assign mul_func_o  = req_func_i;
  assign mul_opr_a_o = req_opr_a_i;
  assign mul_opr_b_o = req_opr_b_i;

  // A result landing on the kill edge belongs to a flushed op.
  assign cap_valid  = sh_valid_q[LATENCY-1] & ~kill_i;
  assign cap_rd     = sh_rd_q[LATENCY-1];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == OCC_W'(FIFO_DEPTH));
  assign pop        = ~fifo_empty & wb_ready_i;

`ifdef MUL_WB_BYPASS_EN
  logic bypass;
  assign bypass = fifo_empty & cap_valid;

  always_comb begin
    if (bypass) begin
      wb_valid_o = 1'b1;
      wb_rd_o    = cap_rd;
      wb_data_o  = mul_res_i;
    end else begin
      wb_valid_o = ~fifo_empty;
      wb_rd_o    = fifo_rd_q[rd_ptr_q];
      wb_data_o  = fifo_data_q[rd_ptr_q];
    end
  end

  assign push = cap_valid & ~(bypass & wb_ready_i);
`else
  assign wb_valid_o = ~fifo_empty;
  assign wb_rd_o    = fifo_rd_q[rd_ptr_q];
  assign wb_data_o  = fifo_data_q[rd_ptr_q];
  assign push       = cap_valid;
`endif

  always_comb begin
    sh_valid_d    = '0;
    sh_valid_d[0] = fire;
    sh_rd_d[0]    = req_rd_i;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      sh_valid_d[i] = sh_valid_q[i-1] & ~kill_i;
      sh_rd_d[i]    = sh_rd_q[i-1];
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) sh_rd_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sh_valid_q <= sh_valid_d;
      sh_rd_q    <= sh_rd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= cap_rd;
      fifo_data_q[wr_ptr_q] <= mul_res_i;
    end
  end

  // Hazard scan covers every in-flight slot and every occupied FIFO entry.
  always_comb begin
    int unsigned fidx;
    hit1 = 1'b0;
    hit2 = 1'b0;
    fidx = 0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      if (sh_valid_q[i]) begin
        hit1 = hit1 | (sh_rd_q[i] == rs1_i);
        hit2 = hit2 | (sh_rd_q[i] == rs2_i);
      end
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      fidx = 32'(rd_ptr_q) + i;
      if (fidx >= FIFO_DEPTH) fidx = fidx - FIFO_DEPTH;
      if (i < 32'(count_q)) begin
        hit1 = hit1 | (fifo_rd_q[fidx[PtrW-1:0]] == rs1_i);
        hit2 = hit2 | (fifo_rd_q[fidx[PtrW-1:0]] == rs2_i);
      end
    end
    hazard_o = ((rs1_i != '0) & hit1) | ((rs2_i != '0) & hit2);
  end

  assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mul_issue_sched.sv
// Bench for mul_issue_sched: emulates the multiplier pipeline and scoreboards writebacks.
module tb_mul_issue_sched;
  localparam int unsigned LAT   = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OW    = 3;
`ifdef MUL_WB_BYPASS_EN
  localparam int unsigned WbLat = LAT;
`else
  localparam int unsigned WbLat = LAT + 1;
`endif
  localparam logic [2:0] FMul = 3'd0, FMulh = 3'd1, FMulhsu = 3'd2, FMulhu = 3'd3;

  logic          clk, reset_n;
  logic          req_valid_i, req_ready_o, kill_i;
  logic [2:0]    req_func_i, mul_func_o;
  logic [4:0]    req_rd_i, wb_rd_o, rs1_i, rs2_i;
  logic [63:0]   req_opr_a_i, req_opr_b_i, mul_opr_a_o, mul_opr_b_o, mul_res_i, wb_data_o;
  logic          mul_instr_o, wb_valid_o, wb_ready_i, hazard_o;
  logic [OW-1:0] occ_o;

  mul_issue_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .OCC_W(OW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_func_i(req_func_i),
    .req_rd_i(req_rd_i), .req_opr_a_i(req_opr_a_i), .req_opr_b_i(req_opr_b_i),
    .kill_i(kill_i), .mul_instr_o(mul_instr_o), .mul_func_o(mul_func_o),
    .mul_opr_a_o(mul_opr_a_o), .mul_opr_b_o(mul_opr_b_o), .mul_res_i(mul_res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o), .occ_o(occ_o)
  );

  typedef struct packed {logic [4:0] rd; logic [63:0] data;} sb_t;
  typedef struct {logic [2:0] func; logic [4:0] rd; logic [63:0] a, b, exp;} vec_t;

  sb_t   sb_q[$];
  vec_t  vecs[7];
  int    n_checks = 0;
  int    n_fail = 0;
  logic [63:0] mpipe [LAT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul_model(input logic [2:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = (f == FMulh || f == FMulhsu) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (f == FMulh) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (f == FMul) ? p[63:0] : p[127:64];
  endfunction

  // Multiplier stand-in: result appears LAT edges after the issue edge, junk otherwise.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mul_instr_o ? mul_model(mul_func_o, mul_opr_a_o, mul_opr_b_o)
                            : 64'hBAD0_BAD0_BAD0_BAD0;
  end
  assign mul_res_i = mpipe[LAT-1];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit track);
    bit done;
    sb_t e;
    done = 1'b0;
    req_valid_i = 1'b1; req_func_i = f; req_rd_i = rd; req_opr_a_i = a; req_opr_b_i = b;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (req_ready_o) begin
        check("mul_instr", 64'(mul_instr_o), 64'd1);
        check("mul_func", 64'(mul_func_o), 64'(f));
        check("mul_opr_a", mul_opr_a_o, a);
        check("mul_opr_b", mul_opr_b_o, b);
        if (track) begin
          e.rd = rd; e.data = exp;
          sb_q.push_back(e);
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check("drain_all", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    sb_t e;
    int  idx, acc;
    bit  found;
    reset_n = 1'b0; req_valid_i = 1'b0; req_func_i = '0; req_rd_i = '0;
    req_opr_a_i = '0; req_opr_b_i = '0; kill_i = 1'b0; wb_ready_i = 1'b0;
    rs1_i = '0; rs2_i = '0;
    vecs[0] = '{FMulhu,  5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    vecs[1] = '{FMulh,   5'd4,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[2] = '{FMul,    5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{FMulhsu, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{FMulhu,  5'd13, 64'h8000_0000_0000_0000, 64'd4, 64'd2};
    vecs[5] = '{FMulh,   5'd14, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{FMulhsu, 5'd15, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'hC000_0000_0000_0000};

    fork
      forever begin
        @(negedge clk);
        if (reset_n && wb_valid_o && wb_ready_i) begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_wb: got rd %0d data %0h, required no writeback",
                     wb_rd_o, wb_data_o);
          end else begin
            e = sb_q.pop_front();
            check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
            check("wb_data", wb_data_o, e.data);
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    check("rst_occ", 64'(occ_o), 64'd0);
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_mul_instr", 64'(mul_instr_o), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single MUL latency
    wb_ready_i = 1'b1;
    issue(FMul, 5'd5, 64'd7, 64'd6, 64'd42, 1'b1);
    for (int c = 1; c <= int'(WbLat); c++) begin
      @(negedge clk);
      check("lat_wb_valid", 64'(wb_valid_o), (c == int'(WbLat)) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check("lat_occ_zero", 64'(occ_o), 64'd0);
    @(posedge clk); #1;

    // Table-driven vectors, back to back
    for (int i = 0; i < 7; i++) issue(vecs[i].func, vecs[i].rd, vecs[i].a, vecs[i].b,
                                      vecs[i].exp, 1'b1);
    drain();

    // Credit limit with writeback stalled
    wb_ready_i = 1'b0;
    idx = 0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 6) begin
        req_valid_i = 1'b1; req_func_i = FMul; req_rd_i = 5'(20 + idx);
        req_opr_a_i = 64'(idx + 1); req_opr_b_i = 64'd100;
      end else req_valid_i = 1'b0;
      @(negedge clk);
      if (req_valid_i && req_ready_o) begin
        e.rd = 5'(20 + idx); e.data = 64'((idx + 1) * 100);
        sb_q.push_back(e);
        acc++; idx++;
      end
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk);
    check("credit_accepted", 64'(acc), 64'd4);
    check("credit_ready", 64'(req_ready_o), 64'd0);
    check("credit_occ", 64'(occ_o), 64'd4);
    @(posedge clk); #1;
    wb_ready_i = 1'b1;
    @(negedge clk);
    check("ready_at_pop", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("ready_after_pop", 64'(req_ready_o), 64'd1);
    @(posedge clk); #1;
    drain();

    // Kill of three in-flight ops
    issue(FMul, 5'd7, 64'd1, 64'd1, 64'd0, 1'b0);
    issue(FMul, 5'd8, 64'd1, 64'd1, 64'd0, 1'b0);
    issue(FMul, 5'd9, 64'd1, 64'd1, 64'd0, 1'b0);
    rs1_i = 5'd8;
    @(posedge clk); #1;
    kill_i = 1'b1;
    @(negedge clk);
    check("kill_hazard_before", 64'(hazard_o), 64'd1);
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(negedge clk);
    check("kill_hazard_after", 64'(hazard_o), 64'd0);
    check("kill_occ", 64'(occ_o), 64'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("kill_no_wb", 64'(wb_valid_o), 64'd0);
    end
    @(posedge clk); #1;
    rs1_i = '0;

    // Hazard lookup
    issue(FMul, 5'd10, 64'd3, 64'd4, 64'd12, 1'b1);
    issue(FMul, 5'd0, 64'd3, 64'd3, 64'd9, 1'b1);
    rs1_i = 5'd10; rs2_i = 5'd0;
    @(negedge clk); check("haz_rs1", 64'(hazard_o), 64'd1);
    @(posedge clk); #1; rs1_i = 5'd0; rs2_i = 5'd10;
    @(negedge clk); check("haz_rs2", 64'(hazard_o), 64'd1);
    @(posedge clk); #1; rs1_i = 5'd0; rs2_i = 5'd11;
    @(negedge clk); check("haz_none", 64'(hazard_o), 64'd0);
    @(posedge clk); #1; rs1_i = 5'd10; rs2_i = 5'd0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (wb_valid_o && wb_rd_o == 5'd10) begin
        check("haz_at_pop", 64'(hazard_o), 64'd1);
        @(negedge clk);
        check("haz_after_pop", 64'(hazard_o), 64'd0);
        found = 1'b1;
      end
    end
    if (!found) check("haz_pop_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    rs1_i = '0;
    drain();

    // Reset mid-flight: one buffered, three in flight
    wb_ready_i = 1'b0;
    issue(FMul, 5'd1, 64'd2, 64'd2, 64'd4, 1'b0);
    repeat (LAT + 1) @(posedge clk);
    #1;
    issue(FMul, 5'd2, 64'd2, 64'd2, 64'd4, 1'b0);
    issue(FMul, 5'd3, 64'd2, 64'd2, 64'd4, 1'b0);
    issue(FMul, 5'd4, 64'd2, 64'd2, 64'd4, 1'b0);
    rs1_i = 5'd1;
    @(negedge clk);
    check("pre_rst_occ", 64'(occ_o), 64'd4);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("mid_rst_occ", 64'(occ_o), 64'd0);
    check("mid_rst_ready", 64'(req_ready_o), 64'd1);
    check("mid_rst_mul_instr", 64'(mul_instr_o), 64'd0);
    check("mid_rst_hazard", 64'(hazard_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1; wb_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("post_rst_no_wb", 64'(wb_valid_o), 64'd0);
    end

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_issue_sched.md
Name: mul_issue_sched

Overview:
Issue scheduler and writeback buffer for the 5-stage pipelined 64-bit multiplier in the execute stage.
- Accepts M-extension multiply ops from issue via valid/ready and drives the multiplier's operand, func and instr inputs.
- Tracks every in-flight op in a shadow pipeline and captures results at the fixed multiplier latency into a result FIFO.
- Presents results on a regfile writeback port with backpressure.
- Provides RAW hazard lookup and kill (flush) of in-flight ops.

Parameters:
LATENCY, 5, multiplier cycles from issue edge to mul_res_i valid; must be >=1.
FIFO_DEPTH, 4, result FIFO entries; also the cap on in-flight plus buffered ops (credit limit).
OCC_W, $clog2(FIFO_DEPTH+1), occupancy counter width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid_i  in  1  multiply op offered
req_ready_o  out  1  scheduler can accept op
req_func_i  in  3  MUL/MULH/MULHSU/MULHU (cpu_consts encoding)
req_rd_i  in  5  destination register
req_opr_a_i  in  64  multiplicand
req_opr_b_i  in  64  multiplier
kill_i  in  1  flush all ops not yet in result FIFO
mul_instr_o  out  1  issue strobe to multiplier
mul_func_o  out  3  func to multiplier
mul_opr_a_o  out  64  operand a to multiplier
mul_opr_b_o  out  64  operand b to multiplier
mul_res_i  in  64  multiplier result, valid LATENCY edges after issue
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback port accepts result
wb_rd_o  out  5  writeback destination
wb_data_o  out  64  writeback data
rs1_i  in  5  hazard query source 1
rs2_i  in  5  hazard query source 2
hazard_o  out  1  rs1/rs2 matches a pending rd
occ_o  out  OCC_W  shadow valids + FIFO count

Behaviour:
- Reset (async assert, sync deassert): shadow valids cleared, FIFO empty, occ_o=0, wb_valid_o=0, mul_instr_o=0, req_ready_o=1.
- Issue fire = req_valid_i & req_ready_o & ~kill_i.
  - mul_instr_o = fire (combinational).
  - mul_opr_a_o, mul_opr_b_o and mul_func_o pass through req_*.
  - A request present with kill_i high is not issued and not recorded.
- Shadow pipeline: LATENCY slots of {valid, rd}. Slot 0 loads {fire, req_rd_i} each edge; slots shift every edge with no stall.
- Capture: at edge E0+LATENCY (E0 = issue edge), the last slot is in its valid cycle.
  - If that slot is valid, {rd, mul_res_i} is pushed into the FIFO.
  - If that slot is invalid (killed), mul_res_i is ignored.
- Credit rule:
  - occ = popcount(shadow valids) + FIFO count.
  - req_ready_o = (occ < FIFO_DEPTH), computed from registered state only. A same-cycle pop does not count, so ready is conservative.
  - The FIFO therefore never overflows; a push into a full FIFO is a design error and must be asserted against.
- Writeback:
  - wb_valid_o = FIFO non-empty; wb_rd_o and wb_data_o come from the FIFO head.
  - Pop on wb_valid_o & wb_ready_i.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Results retire in issue order.
- Kill: at the kill_i edge all shadow valids are cleared.
  - FIFO contents are retained; they are committed.
  - Credits freed are visible next cycle.
  - A result whose capture coincides with the kill edge is killed, not pushed.
- Hazard: hazard_o = 1 if rsN != 0 and it matches the rd of any valid shadow slot or any occupied FIFO entry. rd=0 ops never create hazards. Purely combinational.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are tracked by the count, not pointer equality.
- Reset mid-operation drops all in-flight and buffered ops; multiplier outputs arriving afterwards are ignored because the shadow is invalid.

Optional Feature:
MUL_WB_BYPASS_EN
- Defined:
  - When the FIFO is empty and the capture slot is valid, wb_valid_o, wb_rd_o and wb_data_o are driven combinationally from the slot and mul_res_i in the capture cycle.
  - If wb_ready_i is also high, the result retires without a push (latency = LATENCY cycles).
  - Otherwise it is pushed normally.
- Undefined: wb_valid_o comes from the FIFO only; first writeback is the cycle after the capture edge (latency = LATENCY+1).

Test Plan:
- Reset, wb_ready_i=1, issue MUL rd=5, a=7, b=6 -> wb_valid_o high with wb_rd_o=5, wb_data_o=42 exactly LATENCY+1 cycles after issue (LATENCY with bypass); occ_o returns to 0.
- Back-to-back MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2, then MULH a=b=0xFFFF_FFFF_FFFF_FFFF, rd=3 then 4 -> in-order writebacks 1 (rd 3), then 0 (rd 4).
- wb_ready_i=0, offer 6 ops continuously -> exactly 4 accepted, req_ready_o=0 with occ_o=4; raising wb_ready_i drains 4 results in order; ready reasserts the cycle after the first pop.
- Issue rd=7,8,9 on consecutive cycles, assert kill_i 2 cycles after the last issue -> no writeback for any of them, hazard_o for rs1_i=8 drops next cycle, occ_o=0.
- With rd=10 in flight -> hazard_o=1 for rs1_i=10 or rs2_i=10, 0 for rs1_i=0 and for rd=0 ops; clears the cycle after its pop.
- Assert reset_n=0 mid-flight with 3 ops pending and FIFO holding 1 -> outputs at reset values immediately; no writeback after release.
